// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, crossbar select codes and the port enum
// used by the route allocator, the crossbar and the input FIFOs.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    // Bit positions in the 5-bit per-port vectors
    localparam int IDX_N = 4;
    localparam int IDX_S = 3;
    localparam int IDX_E = 2;
    localparam int IDX_W = 1;
    localparam int IDX_L = 0;

    localparam logic [2:0] SEL_N    = 3'd0;
    localparam logic [2:0] SEL_S    = 3'd1;
    localparam logic [2:0] SEL_E    = 3'd2;
    localparam logic [2:0] SEL_W    = 3'd3;
    localparam logic [2:0] SEL_L    = 3'd4;
    localparam logic [2:0] SEL_IDLE = 3'b111;

    typedef enum logic [2:0] {
        PORT_N    = SEL_N,
        PORT_S    = SEL_S,
        PORT_E    = SEL_E,
        PORT_W    = SEL_W,
        PORT_L    = SEL_L,
        PORT_IDLE = SEL_IDLE
    } port_e;

    // Bit index runs N=4..L=0 while select codes run N=0..L=4
    function automatic logic [2:0] sel_code(input int idx);
        return 3'(IDX_N - idx);
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// 5-way round-robin arbiter with a one-hot priority pointer; the granted
// requester becomes lowest priority when adv_i is asserted.
module noc_rr_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 adv_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic [NUM_PORTS-1:0] ptr;
    logic [NUM_PORTS-1:0] ptr_nxt;
    int                   start;
    int                   idx;
    logic                 found;

    // Search downward from the pointer (N, S, E, W, L order), wrapping L -> N
    always_comb begin
        gnt_o = '0;
        start = 0;
        idx   = 0;
        found = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++)
            if (ptr[j]) start = j;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (start - k + NUM_PORTS) % NUM_PORTS;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Next highest priority is the port just below the winner
    assign ptr_nxt = {gnt_o[0], gnt_o[NUM_PORTS-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= NUM_PORTS'(1) << IDX_N;
        else if (adv_i && (|gnt_o))
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/noc_route_alloc.sv
// Dimension-ordered route decode, per-output round-robin allocation and
// credit tracking for one mesh router node; illegal heads are dropped and counted.
module noc_route_alloc
    import noc_pkg::*;
#(
    parameter int                   COORD_W = 4,
    parameter int                   XCOORD  = 1,
    parameter int                   YCOORD  = 1,
    parameter logic [NUM_PORTS-1:0] PORT_EN = 5'b11111,
    parameter int                   CREDITS = 4,
    parameter bit                   Y_FIRST = 1'b1,
    parameter int                   DROP_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS*2*COORD_W-1:0] dest_i,
    input  logic [NUM_PORTS-1:0]           valid_i,
    input  logic [NUM_PORTS-1:0]           credit_ret_i,
    output logic [NUM_PORTS-1:0]           remove_o,
    output logic [NUM_PORTS-1:0]           credit_inc_o,
    output logic [NUM_PORTS-1:0]           enable_o,
    output logic [NUM_PORTS*3-1:0]         select_o,
    output logic [DROP_W-1:0]              drop_count_o
);

    localparam int                 CW = $clog2(CREDITS + 1);
    localparam int                 DW = 2 * COORD_W;
    localparam logic [COORD_W-1:0] XC = COORD_W'(XCOORD);
    localparam logic [COORD_W-1:0] YC = COORD_W'(YCOORD);

    logic [NUM_PORTS-1:0][COORD_W-1:0]   dx, dy;
    logic [NUM_PORTS-1:0][2:0]           want;
    logic [NUM_PORTS-1:0]                bad, turn_bad, drop;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req, elig, gnt;   // [output][input]
    logic [NUM_PORTS-1:0]                grant_any;
    logic [NUM_PORTS-1:0][CW-1:0]        credit;
    logic [2:0]                          n_drop;
    logic [DROP_W:0]                     drop_sum;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dest
        assign dx[i] = dest_i[i*DW+COORD_W +: COORD_W];
        assign dy[i] = dest_i[i*DW +: COORD_W];
    end

    always_comb begin
        want     = '0;
        bad      = '0;
        turn_bad = '0;
        drop     = '0;
        req      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (Y_FIRST) begin
                if      (dy[i] < YC) want[i] = 3'(IDX_N);
                else if (dy[i] > YC) want[i] = 3'(IDX_S);
                else if (dx[i] > XC) want[i] = 3'(IDX_E);
                else if (dx[i] < XC) want[i] = 3'(IDX_W);
                else                 want[i] = 3'(IDX_L);
                turn_bad[i] = (i == IDX_E || i == IDX_W) && (dy[i] != YC);
            end else begin
                if      (dx[i] > XC) want[i] = 3'(IDX_E);
                else if (dx[i] < XC) want[i] = 3'(IDX_W);
                else if (dy[i] < YC) want[i] = 3'(IDX_N);
                else if (dy[i] > YC) want[i] = 3'(IDX_S);
                else                 want[i] = 3'(IDX_L);
                turn_bad[i] = (i == IDX_N || i == IDX_S) && (dx[i] != XC);
            end
            // want == own index covers both U-turns and an L head addressed to this node
            bad[i] = (want[i] == 3'(i)) || turn_bad[i] || !PORT_EN[want[i]] || !PORT_EN[i];
            drop[i] = valid_i[i] && bad[i];
            if (valid_i[i] && !bad[i])
                req[want[i]][i] = 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
        assign elig[p]      = req[p] & {NUM_PORTS{credit[p] != '0}};
        assign grant_any[p] = |gnt[p];

        noc_rr_arbiter u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req_i (elig[p]),
            .adv_i (grant_any[p]),
            .gnt_o (gnt[p])
        );

        // Simultaneous send and return cancel; a return at full depth is ignored
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                credit[p] <= CW'(CREDITS);
            else if (grant_any[p] && !credit_ret_i[p])
                credit[p] <= credit[p] - CW'(1);
            else if (!grant_any[p] && credit_ret_i[p] && credit[p] != CW'(CREDITS))
                credit[p] <= credit[p] + CW'(1);
        end
    end

    always_comb begin
        remove_o = '0;
        enable_o = '0;
        select_o = {NUM_PORTS{SEL_IDLE}};
        if (rst_n) begin
            remove_o = drop;
            for (int p = 0; p < NUM_PORTS; p++) begin
                enable_o[p] = grant_any[p];
                for (int i = 0; i < NUM_PORTS; i++)
                    if (gnt[p][i]) begin
                        select_o[p*3 +: 3] = sel_code(i);
                        remove_o[i]        = 1'b1;
                    end
            end
        end
    end

    assign credit_inc_o = remove_o;

    assign n_drop   = 3'($countones(drop));
    assign drop_sum = {1'b0, drop_count_o} + (DROP_W + 1)'(n_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count_o <= '0;
        else
            drop_count_o <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

endmodule
